// File: rtl/ram_mux_ctrl_pkg.sv
// Shared types and constants for the cache backing-memory controller.
// Request class decode and FSM state encoding live here so the top and bench agree.
package ram_mux_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 3;
  localparam int unsigned SIG_W      = 3;

  // Bit positions inside the {hit_miss, write_inst, wback} request class
  localparam int unsigned SIG_HIT = 2;
  localparam int unsigned SIG_WR  = 1;
  localparam int unsigned SIG_WB  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    FETCH = 3'd2,
    DONE  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE     = 2'd0,
    REQ_FETCH    = 2'd1,
    REQ_WB_FETCH = 2'd2,
    REQ_WB_ONLY  = 2'd3
  } req_t;

  // Read hits and clean writes need no memory traffic at all
  function automatic req_t decode_req(input logic [SIG_W-1:0] sig);
    req_t r;
    r = REQ_NONE;
    if (sig[SIG_WR] && sig[SIG_WB]) begin
      r = REQ_WB_ONLY;
    end else if (!sig[SIG_HIT] && !sig[SIG_WR]) begin
      r = sig[SIG_WB] ? REQ_WB_FETCH : REQ_FETCH;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_mux_controller_if.sv
// Cache <-> backing-memory controller request/response bundle.
// master = cache side, slave = controller side.
interface ram_mux_controller_if #(
  parameter int unsigned ADDR_W = ram_mux_ctrl_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ram_mux_ctrl_pkg::DATA_W_DEF
);
  logic [ADDR_W-1:0]                  address;
  logic [ram_mux_ctrl_pkg::SIG_W-1:0] signal;
  logic [DATA_W-1:0]                  wb_data;
  logic [ADDR_W-1:0]                  wb_address;
  logic                               controller_running;
  logic [DATA_W-1:0]                  data_out;
  logic                               done;

  modport master (
    output address, signal, wb_data, wb_address, controller_running,
    input  data_out, done
  );

  modport slave (
    input  address, signal, wb_data, wb_address, controller_running,
    output data_out, done
  );
endinterface

// File: rtl/ram_mux_store.sv
// Main RAM: 2**ADDR_W x DATA_W, one synchronous write port, one asynchronous read port.
// Asynchronous reset reloads every word with the low bits of its own address.
module ram_mux_store
  import ram_mux_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/ram_mux_controller.sv
// Backing-memory controller for the 2-way cache: write-back, line fetch, one-cycle done pulse.
// Optional macro WB_FETCH_MERGE_EN: dirty read miss does write-back and fetch in one cycle.
module ram_mux_controller
  import ram_mux_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                 clock,
  input logic                 reset_n,
  ram_mux_controller_if.slave bus
);

  state_t            state_q, state_d;
  logic              fetch_q, fetch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;

  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;

  ram_mux_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en_c),
    .wr_addr   (bus.wb_address),
    .wr_data   (bus.wb_data),
    .rd_addr   (bus.address),
    .rd_data_c (rd_data_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fetch_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // done_d is raised on the edge that enters DONE so the registered pulse lines up with it
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    data_d  = data_q;
    done_d  = 1'b0;
    wr_en_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.controller_running) begin
          case (decode_req(bus.signal))
            REQ_FETCH: begin
              state_d = FETCH;
              fetch_d = 1'b1;
            end
            REQ_WB_FETCH: begin
              state_d = WB;
              fetch_d = 1'b1;
            end
            REQ_WB_ONLY: begin
              state_d = WB;
              fetch_d = 1'b0;
            end
            default: state_d = WAIT;
          endcase
        end
      end

      WB: begin
        wr_en_c = 1'b1;
        data_d  = bus.wb_data;
`ifdef WB_FETCH_MERGE_EN
        // Same-cycle read cannot see the write yet, so forward on an address match
        if (fetch_q && (bus.wb_address != bus.address)) begin
          data_d = rd_data_c;
        end
        state_d = DONE;
        done_d  = 1'b1;
`else
        if (fetch_q) begin
          state_d = FETCH;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`endif
      end

      FETCH: begin
        data_d  = rd_data_c;
        state_d = DONE;
        done_d  = 1'b1;
      end

      DONE: state_d = WAIT;

      // One request per low phase of controller_running
      WAIT: begin
        if (bus.controller_running) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_mux_controller.sv
// Bench for ram_mux_controller: request table with scoreboard, plus early-release and reset sequences.
module tb_ram_mux_controller;
  import ram_mux_ctrl_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;
`ifdef WB_FETCH_MERGE_EN
  localparam int LAT_DIRTY = 2;
`else
  localparam int LAT_DIRTY = 3;
`endif
  localparam int WINDOW = 10;
  localparam int NVEC   = 14;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  ram_mux_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_mux_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]    sig;
    logic [AW-1:0] addr;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    bit            exp_done;
    logic [DW-1:0] exp_data;
    int            exp_lat;
  } vec_t;

  vec_t          vecs [NVEC];
  logic [DW-1:0] sb_q [$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one request, watch a bounded window for done, then release controller_running
  task automatic run_req(input vec_t v, input bit early_release, input string tag);
    int            pulses;
    int            lat;
    logic [DW-1:0] exp;
    pulses = 0;
    lat    = -1;
    @(negedge clock);
    bus.signal             = v.sig;
    bus.address            = v.addr;
    bus.wb_address         = v.wba;
    bus.wb_data            = v.wbd;
    bus.controller_running = 1'b0;
    if (v.exp_done) sb_q.push_back(v.exp_data);
    for (int c = 1; c <= WINDOW; c++) begin
      @(posedge clock);
      #1;
      if (early_release && c == 1) bus.controller_running = 1'b1;
      if (bus.done) begin
        pulses++;
        if (lat < 0) lat = c;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_done: got done=1, expected no pending request", tag);
        end else begin
          exp = sb_q.pop_front();
          check({tag, " data_out"}, 32'(bus.data_out), 32'(exp));
          last_data = exp;
        end
        // Inputs changing after completion must be ignored
        bus.signal     = 3'b001;
        bus.address    = ~v.addr;
        bus.wb_address = ~v.wba;
        bus.wb_data    = ~v.wbd;
      end
    end
    check({tag, " done_pulses"}, 32'(pulses), v.exp_done ? 32'd1 : 32'd0);
    if (v.exp_done) begin
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      if (pulses == 0) sb_q.delete();
    end else begin
      check({tag, " data_held"}, 32'(bus.data_out), 32'(last_data));
    end
    @(negedge clock);
    bus.controller_running = 1'b1;
    repeat (2) @(negedge clock);
    check({tag, " done_idle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t v;
    // sig, addr, wb_address, wb_data, exp_done, exp_data, exp_latency
    vecs[0]  = '{3'b000, 5'd9,  5'd0,  3'd0, 1'b1, 3'd1, 2};         // clean read miss
    vecs[1]  = '{3'b001, 5'd17, 5'd17, 3'd6, 1'b1, 3'd6, LAT_DIRTY}; // dirty miss, same addr
    vecs[2]  = '{3'b000, 5'd17, 5'd0,  3'd0, 1'b1, 3'd6, 2};
    vecs[3]  = '{3'b111, 5'd0,  5'd0,  3'd3, 1'b1, 3'd3, 2};         // write hit dirty
    vecs[4]  = '{3'b000, 5'd0,  5'd0,  3'd0, 1'b1, 3'd3, 2};
    vecs[5]  = '{3'b100, 5'd0,  5'd0,  3'd7, 1'b0, 3'd0, 0};         // read hit
    vecs[6]  = '{3'b110, 5'd5,  5'd5,  3'd7, 1'b0, 3'd0, 0};         // clean write
    vecs[7]  = '{3'b000, 5'd5,  5'd0,  3'd0, 1'b1, 3'd5, 2};
    vecs[8]  = '{3'b011, 5'd0,  5'd31, 3'd2, 1'b1, 3'd2, 2};         // write miss dirty
    vecs[9]  = '{3'b001, 5'd31, 5'd20, 3'd0, 1'b1, 3'd2, LAT_DIRTY}; // dirty miss, diff addr
    vecs[10] = '{3'b000, 5'd20, 5'd0,  3'd0, 1'b1, 3'd0, 2};
    vecs[11] = '{3'b010, 5'd3,  5'd3,  3'd6, 1'b0, 3'd0, 0};
    vecs[12] = '{3'b101, 5'd9,  5'd9,  3'd7, 1'b0, 3'd0, 0};
    vecs[13] = '{3'b000, 5'd9,  5'd0,  3'd0, 1'b1, 3'd1, 2};

    reset_n                = 1'b0;
    bus.controller_running = 1'b1;
    bus.signal             = '0;
    bus.address            = '0;
    bus.wb_address         = '0;
    bus.wb_data            = '0;
    last_data              = '0;
    repeat (3) @(negedge clock);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset data_out", 32'(bus.data_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < NVEC; i++) begin
      run_req(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // controller_running rises right after the request is taken: must still complete
    v = '{3'b000, 5'd17, 5'd0, 3'd0, 1'b1, 3'd6, 2};
    run_req(v, 1'b1, "early_release");

    // Overwrite word 9, then reset in the middle of a fetch of it
    v = '{3'b111, 5'd0, 5'd9, 3'd7, 1'b1, 3'd7, 2};
    run_req(v, 1'b0, "wb9");
    @(negedge clock);
    bus.signal             = 3'b000;
    bus.address            = 5'd9;
    bus.controller_running = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset data_out", 32'(bus.data_out), 32'd0);
    @(negedge clock);
    reset_n                = 1'b1;
    bus.controller_running = 1'b1;
    last_data              = '0;
    repeat (2) @(negedge clock);
    v = '{3'b000, 5'd9, 5'd0, 3'd0, 1'b1, 3'd1, 2};
    run_req(v, 1'b0, "after_reset");

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
